// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the fetch PC, drives the code ROM
// address and queues {pc, inst, fault} in a 2-entry FIFO toward decode.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   imem_addr_o              ROM address (current fetch PC)
//   imem_data_i              combinational ROM read data
//   imem_illegal_i           ROM fault flag for the current address
//   redirect_valid_i/pc_i    flush and restart fetch at a new PC
//   inst_valid_o/ready_i     handshake toward decode
//   inst_o/inst_pc_o         head instruction and its PC
//   inst_fault_o             head entry is a fetch fault
module inst_fetch #(
    parameter int unsigned             ADDR_WIDTH = 64,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    input  logic                  imem_illegal_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_fault_o
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} mode_t;

    mode_t                 r_mode;
    mode_t                 w_mode_nxt;
    logic                  w_run;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [1:0]            r_cnt;
    logic                  r_head;
    logic                  r_tail;

    logic [ADDR_WIDTH-1:0] r_pc_q   [2];
    logic [DATA_WIDTH-1:0] r_inst_q [2];
    logic                  r_flt_q  [2];

    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = (r_cnt != 2'd0) && inst_ready_i;
    // Pop frees a slot in the same cycle, so a full queue still accepts.
    assign w_push = w_run && !redirect_valid_i
                    && ((r_cnt < 2'd2) || w_pop);

    // Mode FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mode <= RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // Mode FSM: next state
    always_comb begin
        w_mode_nxt = r_mode;
        if (redirect_valid_i) begin
            w_mode_nxt = RUN;
        end else if (w_push && imem_illegal_i) begin
            w_mode_nxt = HALT;
        end
    end

    // Mode FSM: outputs
    always_comb begin
        w_run = (r_mode == RUN);
    end

    // Fetch PC, occupancy and pointers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc   <= RESET_PC;
            r_cnt  <= 2'd0;
            r_head <= 1'b0;
            r_tail <= 1'b0;
        end else if (redirect_valid_i) begin
            // A coinciding pop is already complete; the rest is dropped.
            r_pc   <= redirect_pc_i;
            r_cnt  <= 2'd0;
            r_head <= 1'b0;
            r_tail <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= ~r_tail;
                if (!imem_illegal_i) begin
                    r_pc <= r_pc + ADDR_WIDTH'(4);
                end
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Queue storage; contents are only meaningful below r_cnt.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_q[r_tail]   <= r_pc;
            r_inst_q[r_tail] <= imem_illegal_i ? '0 : imem_data_i;
            r_flt_q[r_tail]  <= imem_illegal_i;
        end
    end

    assign imem_addr_o  = r_pc;
    assign inst_valid_o = (r_cnt != 2'd0);
    assign inst_o       = inst_valid_o ? r_inst_q[r_head] : '0;
    assign inst_pc_o    = inst_valid_o ? r_pc_q[r_head]   : '0;
    assign inst_fault_o = inst_valid_o ? r_flt_q[r_head]  : 1'b0;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a reference model fills a
// scoreboard on each modelled push and checks the head every cycle.
module tb_inst_fetch;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        f;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] addr;
    logic [31:0] rdata;
    logic        ill;
    logic        redir = 1'b0;
    logic [63:0] redir_pc = '0;
    logic        valid;
    logic        ready = 1'b1;
    logic [31:0] inst;
    logic [63:0] ipc;
    logic        ifault;

    logic [63:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_ill;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_inst;
    logic [63:0] w_ipc;
    logic        w_fault;

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t sb[$];
    logic [63:0] m_pc = '0;
    bit          m_halt = 1'b0;
    bit          m_ok = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        logic [31:0] d;
        unique case (a)
            64'h0:   d = 32'h0000_0013;
            64'h4:   d = 32'h0010_0093;
            64'h8:   d = 32'h0020_0113;
            default: d = {a[31:2], 2'b11} ^ 32'h5A5A_0000;
        endcase
        return d;
    endfunction

    // Misalignment, plus one aligned fault address used to halt.
    function automatic logic rom_ill(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a == 64'h300);
    endfunction

    assign rdata   = rom(addr);
    assign ill     = rom_ill(addr);
    assign w_rdata = rom(w_addr);
    assign w_ill   = rom_ill(w_addr);

    inst_fetch u_dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_addr_o      (addr),
        .imem_data_i      (rdata),
        .imem_illegal_i   (ill),
        .redirect_valid_i (redir),
        .redirect_pc_i    (redir_pc),
        .inst_valid_o     (valid),
        .inst_ready_i     (ready),
        .inst_o           (inst),
        .inst_pc_o        (ipc),
        .inst_fault_o     (ifault)
    );

    inst_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_addr_o      (w_addr),
        .imem_data_i      (w_rdata),
        .imem_illegal_i   (w_ill),
        .redirect_valid_i (1'b0),
        .redirect_pc_i    (64'h0),
        .inst_valid_o     (w_valid),
        .inst_ready_i     (w_ready),
        .inst_o           (w_inst),
        .inst_pc_o        (w_ipc),
        .inst_fault_o     (w_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model of the main DUT, advanced on each rising edge.
    always @(posedge clk) begin
        int  sz;
        bit  pop;
        m_ok = 1'b1;
        if (!rst_n) begin
            sb.delete();
            m_pc   = '0;
            m_halt = 1'b0;
        end else begin
            sz  = sb.size();
            pop = (sz != 0) && ready;
            if (pop) void'(sb.pop_front());
            if (redir) begin
                sb.delete();
                m_pc   = redir_pc;
                m_halt = 1'b0;
            end else if (!m_halt && (sz < 2 || pop)) begin
                if (rom_ill(m_pc)) begin
                    sb.push_back('{m_pc, 32'h0, 1'b1});
                    m_halt = 1'b1;
                end else begin
                    sb.push_back('{m_pc, rom(m_pc), 1'b0});
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    end

    // Scoreboard comparison every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("addr", addr, m_pc);
            chk("valid", 64'(valid), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("pc", ipc, sb[0].pc);
                chk("inst", 64'(inst), 64'(sb[0].inst));
                chk("fault", 64'(ifault), 64'(sb[0].f));
            end else begin
                chk("idle_out", {ipc[31:0], inst}, 64'h0);
                chk("idle_flt", 64'(ifault), 64'h0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_redir(input logic [63:0] pc);
        redir    = 1'b1;
        redir_pc = pc;
        cyc(1);
        redir    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b1;
        cyc(2);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_addr", addr, 64'h0);
        chk("rst_waddr", w_addr, WRAP_PC);
        rst_n = 1'b1;

        cyc(1);
        chk("seq0_pc", ipc, 64'h0);
        chk("seq0_inst", 64'(inst), 64'h13);
        chk("wrap0", w_ipc, 64'hFFFF_FFFF_FFFF_FFF8);
        cyc(1);
        chk("seq1_pc", ipc, 64'h4);
        chk("seq1_inst", 64'(inst), 64'h0010_0093);
        chk("wrap1", w_ipc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1);
        chk("seq2_pc", ipc, 64'h8);
        chk("seq2_inst", 64'(inst), 64'h0020_0113);
        chk("wrap2", w_ipc, 64'h0);
        chk("wrap2_v", 64'(w_valid), 64'h1);

        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        ready = 1'b0;
        cyc(5);
        chk("bp_addr", addr, 64'h8);
        chk("bp_head", ipc, 64'h0);
        ready = 1'b1;
        chk("bp_rel0", ipc, 64'h0);
        cyc(1);
        chk("bp_rel1", ipc, 64'h4);
        cyc(1);
        chk("bp_rel2", ipc, 64'h8);

        ready = 1'b0;
        do_redir(64'h10);
        cyc(3);
        chk("fl_head", ipc, 64'h10);
        chk("fl_addr", addr, 64'h18);
        ready = 1'b1;
        do_redir(64'h40);
        chk("fl_bubble", 64'(valid), 64'h0);
        cyc(1);
        chk("fl_tgt", ipc, 64'h40);

        ready = 1'b0;
        do_redir(64'h102);
        cyc(1);
        chk("flt_pc", ipc, 64'h102);
        chk("flt_inst", 64'(inst), 64'h0);
        chk("flt_bit", 64'(ifault), 64'h1);
        ready = 1'b1;
        cyc(1);
        cyc(10);
        chk("flt_idle", 64'(valid), 64'h0);
        chk("flt_addr", addr, 64'h102);
        do_redir(64'h100);
        cyc(1);
        chk("flt_resume", ipc, 64'h100);

        ready = 1'b0;
        do_redir(64'h2FC);
        cyc(3);
        chk("halt_head", ipc, 64'h2FC);
        chk("halt_addr", addr, 64'h300);
        rst_n = 1'b0;
        cyc(1);
        chk("mrst_valid", 64'(valid), 64'h0);
        chk("mrst_addr", addr, 64'h0);
        rst_n = 1'b1;
        ready = 1'b1;
        cyc(1);
        chk("mrst_pc", ipc, 64'h0);
        chk("mrst_v", 64'(valid), 64'h1);
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch front end: the requester side of the code ROM port. It owns the fetch PC and drives the ROM address. It captures each combinational ROM response, including its misalignment fault flag, into a 2-entry queue. It delivers {pc, instruction, fault} to decode over a valid/ready handshake. Redirects from execute (branch, jump, trap) flush the queue and restart fetch.

## Interface
- ADDR_WIDTH, 64, fetch PC / ROM address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, fetch PC loaded on reset
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- imem_addr_o  output  ADDR_WIDTH  ROM address, equals current fetch PC
- imem_data_i  input  DATA_WIDTH  ROM read data (combinational response to imem_addr_o)
- imem_illegal_i  input  1  ROM fault flag (address not 4-byte aligned)
- redirect_valid_i  input  1  redirect request
- redirect_pc_i  input  ADDR_WIDTH  redirect target
- inst_valid_o  output  1  queue head valid
- inst_ready_i  input  1  decode accepts head
- inst_o  output  DATA_WIDTH  head instruction
- inst_pc_o  output  ADDR_WIDTH  head PC
- inst_fault_o  output  1  head is a fetch fault

## Operation
- State:
  - fetch_pc
  - mode ∈ {RUN, HALT}
  - 2-entry FIFO of {pc, inst, fault}, with occupancy count 0..2 and head/tail pointers
- imem_addr_o = fetch_pc at all times, including HALT.
- pop = inst_valid_o & inst_ready_i.
- push = mode==RUN & !redirect_valid_i & (count<2 | pop).
- On push:
  - Entry written is {fetch_pc, imem_data_i, imem_illegal_i}.
  - If imem_illegal_i=0: fetch_pc <= fetch_pc+4, modulo 2^ADDR_WIDTH; wrap from all-ones-minus-3 to 0 is silent.
  - If imem_illegal_i=1: inst field is forced to 0, fault=1, mode <= HALT, fetch_pc unchanged.
- HALT: no pushes. Existing entries, including the fault entry, still drain normally. HALT is left only by a redirect.
- Redirect, which has priority over push:
  - fetch_pc <= redirect_pc_i, count <= 0, mode <= RUN.
  - No push that cycle.
  - A pop coinciding with a redirect is a completed transfer; the flush discards only the remaining entries.
- Push and pop in the same cycle with count==2: legal, count stays 2.
- Push and pop with count==0 cannot coincide, because the output is not bypassed.
- Misaligned redirect targets are not checked locally. The ROM's fault flag produces the fault entry on the next cycle.
- inst_valid_o = (count != 0). inst_o, inst_pc_o and inst_fault_o show the head entry and are held stable while valid & !ready.
- When count==0, inst_o, inst_pc_o and inst_fault_o are driven to 0.

## Timing
- Reset (rst_ni=0 at an edge):
  - count=0, mode=RUN, fetch_pc=RESET_PC.
  - Outputs: inst_valid_o=0, inst_o=0, inst_pc_o=0, inst_fault_o=0, imem_addr_o=RESET_PC.
  - Reset asserted mid-stream discards all entries and any pending redirect.
- First fetch happens on the first edge with rst_ni=1. inst_valid_o rises one cycle later.
- Fetch-to-output latency: 1 cycle.
- Sustained throughput: 1 instruction per cycle while inst_ready_i=1.
- Redirect sampled at edge N:
  - Target fetched at edge N+1.
  - Target appears on inst_* after edge N+1.
  - inst_valid_o=0 for exactly one cycle, the one after edge N.
- Backpressure: with inst_ready_i=0, fetch continues until count==2, then stalls. fetch_pc holds at the next unfetched PC.
- No combinational path from inputs to inst_*. imem_addr_o depends only on state.

## Test plan
- Sequential fetch: reset, ROM words 0x00000013, 0x00100093, 0x00200113 at 0x0/0x4/0x8, inst_ready_i=1 → inst_valid_o high from cycle 1, with (pc,inst) = (0x0,0x00000013), (0x4,0x00100093), (0x8,0x00200113) on consecutive cycles.
- Backpressure: hold inst_ready_i=0 for 5 cycles after reset → count saturates at 2, imem_addr_o stays 0x8, head stays pc 0x0. On release, pcs 0x0, 0x4, 0x8 are delivered on consecutive cycles with none lost or duplicated.
- Redirect flush: with queue full (pc 0x10, 0x14), assert redirect_valid_i, redirect_pc_i=0x40, inst_ready_i=1 → pc 0x10 is accepted that cycle, 0x14 is dropped, inst_valid_o=0 for one cycle, next head pc=0x40.
- Fault: redirect to 0x102 → one entry pc=0x102, inst=0, fault=1. No further entries while idle for 10 cycles. Redirect to 0x100 resumes with pc 0x100.
- Wrap: RESET_PC=2^64−8 → pcs 0xFFFF_FFFF_FFFF_FFF8, 0xFFFF_FFFF_FFFF_FFFC, 0x0 delivered in sequence.
- Mid-stream reset: pull rst_ni low for 1 cycle with 2 entries queued and HALT mode → next cycle inst_valid_o=0, imem_addr_o=RESET_PC. Fetch restarts normally.
